integer_exp_lut_arbiter: RTL and testbench

Shares one 16-entry e^-k lookup table among NUM_REQ independent requesters inside the fixed-point scalar operator library. Each requester presents an unsigned integer exponent magnitude k and receives e^-k as an unsigned Q1.16 value (17 bits, 0x10000 = 1.0). A round-robin arbiter grants at most one lookup per cycle. The result is registered into a per-requester one-entry response buffer, which uses its own valid/ready handshake. Typical clients are softmax and exponent-decay lanes that each need an exp value only occasionally.

---
 rtl/integer_exp_lut_arbiter.sv | 143 ++++++++++++++
 tb/tb_integer_exp_lut_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/integer_exp_lut_arbiter.sv
// ---------------------------------------------------------------------------
// integer_exp_lut_arbiter
//
// One 16-entry e^-k lookup table shared by NUM_REQ requesters. A round-robin
// arbiter grants at most one lookup per cycle. The result lands in a
// per-requester one-entry response slot that has its own valid/ready
// handshake. Results are unsigned Q1.16 (17 bits, 0x10000 = 1.0).
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req_valid    [NUM_REQ]            requester i presents a lookup
//   req_ready    [NUM_REQ]            one-hot (or zero) combinational grant
//   req_address  [NUM_REQ*IN_WIDTH]   exponent magnitude k, slot i at i*IN_WIDTH
//   resp_valid   [NUM_REQ]            slot i holds a result
//   resp_ready   [NUM_REQ]            requester i accepts its result
//   resp_data    [NUM_REQ*17]         result, slot i at i*17
// ---------------------------------------------------------------------------
module integer_exp_lut_arbiter #(
    parameter int NUM_REQ  = 4,   // 2..8
    parameter int IN_WIDTH = 8    // >= 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*IN_WIDTH-1:0]  req_address,
    output logic [NUM_REQ-1:0]           resp_valid,
    input  logic [NUM_REQ-1:0]           resp_ready,
    output logic [NUM_REQ*17-1:0]        resp_data
);

    localparam int DATA_WIDTH = 17;
    localparam int PTR_W      = $clog2(NUM_REQ);

    // e^-k in Q1.16; any k above 15 yields 0 without consulting the table.
    function automatic logic [DATA_WIDTH-1:0] exp_lut(input logic [IN_WIDTH-1:0] k);
        logic [DATA_WIDTH-1:0] val;
        val = '0;
        if ((k >> 4) == '0) begin
            case (k[3:0])
                4'd0:    val = 17'h10000;
                4'd1:    val = 17'h05E2D;
                4'd2:    val = 17'h022A5;
                4'd3:    val = 17'h00CBE;
                4'd4:    val = 17'h004B0;
                4'd5:    val = 17'h001B9;
                4'd6:    val = 17'h000A2;
                4'd7:    val = 17'h0003B;
                4'd8:    val = 17'h00015;
                4'd9:    val = 17'h00008;
                4'd10:   val = 17'h00002;
                4'd11:   val = 17'h00001;
                default: val = '0;
            endcase
        end
        return val;
    endfunction

    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [NUM_REQ-1:0]    resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_data_q [NUM_REQ];
    logic [DATA_WIDTH-1:0] resp_data_d [NUM_REQ];

    logic [NUM_REQ-1:0]    eligible;
    logic                  gnt_found;
    logic [PTR_W-1:0]      gnt_idx;
    logic [IN_WIDTH-1:0]   lut_addr;
    logic [DATA_WIDTH-1:0] lut_data;

    // A full slot may take a new result when it is being drained this cycle.
    assign eligible = req_valid & (~resp_valid_q | resp_ready);

    // Round-robin search starting at ptr_q, wrapping modulo NUM_REQ.
    // NOTE: combinational blocks use blocking assignments and give every
    // output a default first, so no latch is inferred.
    always_comb begin
        logic [PTR_W-1:0] cand;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = PTR_W'((int'(ptr_q) + off) % NUM_REQ);
            if (!gnt_found && eligible[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign req_ready = gnt_found ? (NUM_REQ'(1) << gnt_idx) : '0;

    // Single table instance fed by the granted requester's address only.
    assign lut_addr = req_address[int'(gnt_idx)*IN_WIDTH +: IN_WIDTH];
    assign lut_data = exp_lut(lut_addr);

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_found) begin
            ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

    // Grant wins over drain, so a drain plus refill in one cycle leaves
    // the slot valid with the new data.
    always_comb begin
        resp_valid_d = resp_valid_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_data_d[i] = resp_data_q[i];
            if (req_ready[i]) begin
                resp_valid_d[i] = 1'b1;
                resp_data_d[i]  = lut_data;
            end else if (resp_ready[i]) begin
                resp_valid_d[i] = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments. The data slots are
    // reset as well because resp_data must read 0 during and after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q        <= '0;
            resp_valid_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                resp_data_q[i] <= '0;
            end
        end else begin
            ptr_q        <= ptr_d;
            resp_valid_q <= resp_valid_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                resp_data_q[i] <= resp_data_d[i];
            end
        end
    end

    assign resp_valid = resp_valid_q;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_flat
        assign resp_data[g*DATA_WIDTH +: DATA_WIDTH] = resp_data_q[g];
    end

endmodule

// File: tb/tb_integer_exp_lut_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for integer_exp_lut_arbiter (NUM_REQ = 4, IN_WIDTH = 8).
// Inputs are driven on the falling edge; req_ready is sampled 1 ns after
// that, registered outputs 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_integer_exp_lut_arbiter;

    localparam int N  = 4;
    localparam int IW = 8;
    localparam int DW = 17;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*IW-1:0] req_address = '0;
    logic [N-1:0]    resp_valid;
    logic [N-1:0]    resp_ready = '0;
    logic [N*DW-1:0] resp_data;

    integer_exp_lut_arbiter #(.NUM_REQ(N), .IN_WIDTH(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_address(req_address),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [IW-1:0] k;
        logic [DW-1:0] exp_val;
    } vec_t;

    vec_t          sweep [23];
    logic [DW-1:0] ref_tab [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [DW-1:0] slot(input int i);
        return resp_data[i*DW +: DW];
    endfunction

    task automatic set_addr(input int i, input logic [IW-1:0] k);
        req_address[i*IW +: IW] = k;
    endtask

    // Apply reset across one rising edge, release on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        req_valid   = '0;
        resp_ready  = '0;
        req_address = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ref_tab = '{17'h10000, 17'h05E2D, 17'h022A5, 17'h00CBE, 17'h004B0, 17'h001B9,
                    17'h000A2, 17'h0003B, 17'h00015, 17'h00008, 17'h00002, 17'h00001};
        for (int i = 0; i <= 20; i++) begin
            sweep[i].k       = IW'(i);
            sweep[i].exp_val = (i < 12) ? ref_tab[i] : '0;
        end
        sweep[21].k = 8'd16;  sweep[21].exp_val = '0;
        sweep[22].k = 8'd255; sweep[22].exp_val = '0;

        // ---------------- reset state ----------------
        #3;
        check("reset resp_valid", 32'(resp_valid), 32'h0);
        check("reset resp_data0", 32'(slot(0)), 32'h0);
        do_reset();

        // ---------------- single requester sweep ----------------
        resp_ready = '1;
        for (int v = 0; v < 23; v++) begin
            req_valid = 4'b0001;
            set_addr(0, sweep[v].k);
            #1;
            check($sformatf("sweep k=%0d ready", sweep[v].k), 32'(req_ready), 32'h1);
            after_edge();
            check($sformatf("sweep k=%0d valid", sweep[v].k), 32'(resp_valid[0]), 32'h1);
            check($sformatf("sweep k=%0d data", sweep[v].k), 32'(slot(0)), 32'(sweep[v].exp_val));
            to_neg();
        end
        req_valid = '0;
        after_edge();
        check("sweep drained", 32'(resp_valid), 32'h0);

        // ---------------- full contention ----------------
        do_reset();
        resp_ready = '1;
        req_valid  = '1;
        for (int i = 0; i < N; i++) set_addr(i, IW'(i + 1));
        for (int c = 0; c < 8; c++) begin
            #1;
            check($sformatf("contention grant c=%0d", c), 32'(req_ready), 32'(1 << (c % N)));
            after_edge();
            check($sformatf("contention data c=%0d", c), 32'(slot(c % N)), 32'(ref_tab[c % N + 1]));
            to_neg();
        end

        // ---------------- backpressure ----------------
        do_reset();
        resp_ready = 4'b1101;
        req_valid  = 4'b0010;
        set_addr(1, 8'd2);
        after_edge();
        check("bp slot1 filled", 32'(slot(1)), 32'h022A5);
        to_neg();
        req_valid = 4'b1111;
        set_addr(0, 8'd1); set_addr(1, 8'd5); set_addr(2, 8'd3); set_addr(3, 8'd4);
        #1;
        check("bp grant 2 (ptr=2)", 32'(req_ready), 32'h4);
        after_edge();
        check("bp slot2 data", 32'(slot(2)), 32'h00CBE);
        check("bp slot1 stable a", 32'(slot(1)), 32'h022A5);
        to_neg(); #1;
        check("bp grant 3", 32'(req_ready), 32'h8);
        after_edge(); to_neg(); #1;
        check("bp grant 0", 32'(req_ready), 32'h1);
        after_edge(); to_neg(); #1;
        check("bp skip 1 grant 2", 32'(req_ready), 32'h4);
        after_edge();
        check("bp slot1 valid held", 32'(resp_valid[1]), 32'h1);
        check("bp slot1 stable b", 32'(slot(1)), 32'h022A5);
        to_neg();
        req_valid = 4'b0010;
        #1;
        check("bp blocked no grant", 32'(req_ready), 32'h0);
        resp_ready = 4'b1111;
        #1;
        check("bp release grant 1", 32'(req_ready), 32'h2);
        after_edge();
        check("bp slot1 new data", 32'(slot(1)), 32'h001B9);
        check("bp slot1 valid", 32'(resp_valid[1]), 32'h1);

        // ---------------- drain and refill ----------------
        do_reset();
        req_valid = 4'b0001;
        set_addr(0, 8'd1);
        after_edge();
        check("dr first data", 32'(slot(0)), 32'h05E2D);
        to_neg();
        set_addr(0, 8'd4);
        #1;
        check("dr full no grant", 32'(req_ready), 32'h0);
        after_edge();
        check("dr held data", 32'(slot(0)), 32'h05E2D);
        to_neg();
        resp_ready = 4'b0001;
        #1;
        check("dr refill grant", 32'(req_ready), 32'h1);
        after_edge();
        check("dr no bubble", 32'(resp_valid[0]), 32'h1);
        check("dr new data", 32'(slot(0)), 32'h004B0);
        to_neg();
        req_valid = '0;
        after_edge();
        check("dr drained", 32'(resp_valid[0]), 32'h0);

        // ---------------- pointer wrap ----------------
        do_reset();
        resp_ready = '1;
        #1;
        check("wrap idle", 32'(req_ready), 32'h0);
        to_neg();
        req_valid = 4'b1000;
        set_addr(3, 8'd0);
        #1;
        check("wrap grant 3", 32'(req_ready), 32'h8);
        after_edge();
        check("wrap slot3", 32'(slot(3)), 32'h10000);
        to_neg();
        req_valid = 4'b0001;
        set_addr(0, 8'd2);
        #1;
        check("wrap grant 0", 32'(req_ready), 32'h1);
        after_edge();
        check("wrap slot0", 32'(slot(0)), 32'h022A5);
        to_neg();
        req_valid = 4'b1111;
        #1;
        check("wrap ptr now 1", 32'(req_ready), 32'h2);

        // ---------------- reset mid-operation ----------------
        do_reset();
        resp_ready = '0;
        req_valid  = '1;
        for (int i = 0; i < N; i++) set_addr(i, IW'(i));
        repeat (4) after_edge();
        check("rst all slots full", 32'(resp_valid), 32'hF);
        check("rst slot3 data", 32'(slot(3)), 32'h00CBE);
        to_neg();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst async valid", 32'(resp_valid), 32'h0);
        check("rst async data", 32'(resp_data[63:32]) | 32'(resp_data[31:0]), 32'h0);
        after_edge();
        check("rst held valid", 32'(resp_valid), 32'h0);
        check("rst held data", 32'(slot(3)), 32'h0);
        to_neg();
        rst_n     = 1'b1;
        req_valid = 4'b0110;
        #1;
        check("rst first grant lowest", 32'(req_ready), 32'h2);
        after_edge();
        check("rst post grant valid", 32'(resp_valid), 32'h2);
        check("rst post grant data", 32'(slot(1)), 32'h05E2D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
